// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit driving a byte-addressed data memory
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned half/word accesses instead of issuing them)
module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  output logic            resp_misaligned,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [2:0]      mem_width,
  output logic            mem_read_en,
  output logic            mem_write_en,
  input  logic [XLEN-1:0] mem_valM,
  input  logic            mem_fault
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic              mis_q, mis_d;

  logic              bad_funct3;
  logic              illegal;
  logic              misaligned;
  logic [XLEN-1:0]   load_ext;

  always_comb begin
    bad_funct3 = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    illegal    = bad_funct3 || (req_we && req_funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    // Alignment wins over the store/unsigned check, but never over an undefined funct3.
    misaligned = !bad_funct3 &&
                 (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                  ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
`else
    misaligned = 1'b0;
`endif
  end

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{(XLEN-8){mem_valM[7]}}, mem_valM[7:0]};
      3'b001:  load_ext = {{(XLEN-16){mem_valM[15]}}, mem_valM[15:0]};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, mem_valM[7:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, mem_valM[15:0]};
      default: load_ext = mem_valM;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    fault_d  = fault_q;
    mis_d    = mis_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          fault_d  = 1'b0;
          mis_d    = 1'b0;
          if (misaligned) begin
            mis_d   = 1'b1;
            state_d = RESP;
          end else if (illegal) begin
            fault_d = 1'b1;
            state_d = RESP;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        fault_d = mem_fault;
        rdata_d = (!we_q && !mem_fault) ? load_ext : '0;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
      mis_q    <= mis_d;
    end
  end

  // Address/data/width simply mirror the latched request; only the enables gate memory.
  assign req_ready       = (state_q == IDLE);
  assign resp_valid      = (state_q == RESP);
  assign resp_rdata      = rdata_q;
  assign resp_fault      = fault_q;
  assign resp_misaligned = mis_q;
  assign mem_addr        = addr_q;
  assign mem_wdata       = wdata_q;
  assign mem_width       = {1'b0, funct3_q[1:0]};
  assign mem_read_en     = (state_q == ACCESS) && !we_q;
  assign mem_write_en    = (state_q == ACCESS) && we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed and random checks of load_store_unit against a byte-array reference
module tb_load_store_unit;

  localparam int MEM_SIZE = 1024;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        resp_misaligned;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_width;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_valM;
  logic        mem_fault;

  load_store_unit #(.XLEN(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .resp_misaligned(resp_misaligned),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_width(mem_width),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_valM(mem_valM), .mem_fault(mem_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [7:0] dmem    [0:MEM_SIZE-1];
  logic [7:0] ref_mem [0:MEM_SIZE-1];
  int errors = 0;
  int checks = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  // Memory: byte-granular, faults on address 0 or any access running past the end.
  int nbytes;
  always_comb begin
    nbytes    = 1 << mem_width[1:0];
    mem_fault = (mem_read_en || mem_write_en) &&
                ((mem_addr == 32'd0) || (longint'(mem_addr) + nbytes > MEM_SIZE));
    mem_valM  = 32'd0;
    for (int k = 0; k < 4; k++)
      if (k < nbytes) mem_valM[8*k +: 8] = dmem[10'(mem_addr + 32'(k))];
  end

  always @(posedge clock) begin
    if (mem_write_en && !mem_fault)
      for (int k = 0; k < 4; k++)
        if (k < nbytes) dmem[10'(mem_addr + 32'(k))] <= mem_wdata[8*k +: 8];
  end

  always @(negedge clock) begin
    if (mem_read_en) rd_cnt++;
    if (mem_write_en) wr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ref_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic fault, output logic mis, output int lat,
                        output int rd, output int wr);
    int n;
    logic bad;
    longint v;
    bad = (f3 == 3) || (f3 == 6) || (f3 == 7);
    n = 1 << f3[1:0];
    rdata = 0; fault = 0; mis = 0; lat = 1; rd = 0; wr = 0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (!bad && (addr % n) != 0) mis = 1;
`endif
    if (mis) begin
    end else if (bad || (we && f3[2])) begin
      fault = 1;
    end else begin
      lat = 2;
      rd = we ? 0 : 1;
      wr = we ? 1 : 0;
      fault = (addr == 0) || (longint'(addr) + n > MEM_SIZE);
      if (!fault) begin
        if (we) begin
          for (int k = 0; k < n; k++) ref_mem[(addr + k) % MEM_SIZE] = 8'(wdata >> (8 * k));
        end else begin
          v = 0;
          for (int k = 0; k < n; k++) v += longint'(ref_mem[(addr + k) % MEM_SIZE]) << (8 * k);
          if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
          rdata = v[31:0];
        end
      end
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output int waited);
    @(negedge clock);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 10) begin
      @(negedge clock);
      waited++;
    end
    chk("accept", 32'(req_ready), 32'd1);
    @(posedge clock);
    #1 req_valid = 1'b0;
    rd_cnt = 0;
    wr_cnt = 0;
  endtask

  task automatic finish_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input int stall);
    logic [31:0] er; logic ef, em; int el, erd, ewr, n;
    ref_op(we, f3, addr, wdata, er, ef, em, el, erd, ewr);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!resp_valid && n < 10);
    chk("latency", 32'(n), 32'(el));
    chk("rdata", resp_rdata, er);
    chk("fault", 32'(resp_fault), 32'(ef));
    chk("misaligned", 32'(resp_misaligned), 32'(em));
    chk("read_en_cycles", 32'(rd_cnt), 32'(erd));
    chk("write_en_cycles", 32'(wr_cnt), 32'(ewr));
    for (int s = 0; s < stall; s++) begin
      @(negedge clock);
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_rdata", resp_rdata, er);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_write_en_cycles", 32'(wr_cnt), 32'(ewr));
    end
    @(negedge clock);
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;
  endtask

  task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wdata, input int stall);
    int w;
    issue(we, f3, addr, wdata, w);
    finish_req(we, f3, addr, wdata, stall);
  endtask

  initial begin
    int w;
    for (int i = 0; i < MEM_SIZE; i++) begin
      dmem[i] = 8'(i * 37 + 5);
      ref_mem[i] = 8'(i * 37 + 5);
    end
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_rdata", resp_rdata, 32'd0);
    chk("reset_fault", 32'(resp_fault), 32'd0);
    chk("reset_misaligned", 32'(resp_misaligned), 32'd0);
    chk("reset_enables", {30'd0, mem_read_en, mem_write_en}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    chk("reset_mem_width", 32'(mem_width), 32'd0);

    op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
    op(1'b0, 3'b010, 32'h10, 32'h0, 0);
    op(1'b0, 3'b000, 32'h13, 32'h0, 0);
    op(1'b0, 3'b100, 32'h13, 32'h0, 0);
    op(1'b0, 3'b001, 32'h12, 32'h0, 0);
    op(1'b0, 3'b101, 32'h10, 32'h0, 0);

    op(1'b0, 3'b010, 32'd0, 32'h0, 0);
    op(1'b0, 3'b010, 32'd1022, 32'h0, 0);
    op(1'b1, 3'b010, 32'd1022, 32'h12345678, 0);
    op(1'b0, 3'b100, 32'd1022, 32'h0, 0);
    op(1'b0, 3'b100, 32'd1023, 32'h0, 0);

    op(1'b0, 3'b011, 32'h20, 32'h0, 0);
    op(1'b1, 3'b100, 32'h20, 32'hFFFFFFFF, 0);

    // Response stall with a competing request held on the input.
    issue(1'b0, 3'b010, 32'h10, 32'h0, w);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    req_valid = 1'b1;
    finish_req(1'b0, 3'b010, 32'h10, 32'h0, 5);
    issue(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, w);
    chk("accept_after_handshake_wait", 32'(w), 32'd0);
    finish_req(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 0);
    op(1'b0, 3'b010, 32'h20, 32'h0, 0);

    // Reset while the load is in its memory cycle.
    issue(1'b0, 3'b010, 32'h40, 32'h0, w);
    chk("access_read_en", 32'(mem_read_en), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_read_en", 32'(mem_read_en), 32'd0);
    chk("rst_mid_rdata", resp_rdata, 32'd0);

    op(1'b0, 3'b010, 32'h11, 32'h0, 0);
    op(1'b0, 3'b001, 32'h31, 32'h0, 0);
    op(1'b1, 3'b101, 32'h33, 32'h0, 0);

    for (int i = 0; i < 40; i++) begin
      logic rwe; logic [2:0] rf3; logic [31:0] raddr;
      rwe = 1'($urandom_range(0, 1));
      rf3 = 3'($urandom_range(0, 7));
      raddr = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 1023));
      op(rwe, rf3, raddr, $urandom, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the core's data-memory port: takes one load/store request from the execute stage and drives the byte-addressed data memory.
- Memory port: addr, wdata, width, read_en, write_en, valM, mem_fault.
- Captures read data and fault status, applies RISC-V load sign/zero extension, returns a registered response to writeback.
- One outstanding request; valid/ready handshakes on both pipeline sides.

Parameters:
- XLEN, 32, data and address width; only 32 is supported.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, low bytes used.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  XLEN  extended load data; 0 for stores and faults.
- resp_fault  out  1  access fault: illegal funct3 or memory fault.
- resp_misaligned  out  1  misaligned-access exception (see Optional Feature).
- mem_addr  out  XLEN  to memory addr.
- mem_wdata  out  XLEN  to memory wdata.
- mem_width  out  3  to memory width = {1'b0, funct3[1:0]}.
- mem_read_en  out  1  to memory read_en.
- mem_write_en  out  1  to memory write_en.
- mem_valM  in  XLEN  combinational read data from memory.
- mem_fault  in  1  combinational fault from memory.

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, resp_misaligned=0, mem_read_en=0, mem_write_en=0, mem_addr=0, mem_wdata=0, mem_width=0.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/funct3/addr/wdata.
  - Illegal request: funct3 in {011, 110, 111}, or req_we=1 with funct3[2]=1. Go to RESP with resp_fault=1; no memory access.
  - Otherwise go to ACCESS.
- ACCESS (exactly one cycle):
  - req_ready=0.
  - mem_addr, mem_wdata and mem_width come from the latched registers.
  - mem_read_en = !we; mem_write_en = we. Both enables are 0 in every other state.
  - At the end of the cycle, capture mem_fault into resp_fault.
  - For a load without fault, capture the extended mem_valM into resp_rdata:
    - funct3 000: sign-extend bit 7.
    - funct3 001: sign-extend bit 15.
    - funct3 010: pass through.
    - funct3 100: zero-extend byte.
    - funct3 101: zero-extend half.
  - Stores commit in memory on the ACCESS-ending edge. On a store fault the memory suppresses the write and the LSU reports resp_fault=1.
  - Go to RESP.
- RESP:
  - resp_valid=1, req_ready=0.
  - Outputs stay stable until resp_ready=1. At that edge go to IDLE and clear resp_valid.
  - A new request is not accepted in the same cycle as the response handshake.
- Latency: request accepted at edge E0 gives resp_valid=1 after E0+2, or after E0+1 for illegal/misaligned requests.
- Throughput: at most one request per 3 cycles with resp_ready held high.
- resp_rdata=0 whenever resp_fault=1, resp_misaligned=1, or the request is a store.
- mem_addr, mem_wdata and mem_width hold their last latched values outside ACCESS; only the enables gate memory activity.
- Reset mid-operation:
  - Return to IDLE; the pending response is discarded.
  - A store in ACCESS at the reset edge still commits, because memory samples the same edge.
- Holding req_valid high while req_ready=0 has no effect.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Halfword requests with addr[0]=1, or word requests with addr[1:0]!=0, go IDLE to RESP.
  - resp_misaligned=1, resp_fault=0, no memory enable asserted.
  - Alignment is checked before the illegal-funct3 check only for legal funct3 values.
- Undefined:
  - Misaligned accesses go to memory unchanged, since memory supports byte-granular multi-byte access.
  - resp_misaligned is tied to 0.

Test Plan:
- Store SW addr=0x10, wdata=0xDEADBEEF, then load LW 0x10 -> mem_write_en high exactly one cycle; load resp_rdata=0xDEADBEEF, resp_fault=0, resp_valid 2 cycles after acceptance.
- After the above, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- LW addr=0 and LW addr=1022 (MEM_SIZE=1024) -> resp_fault=1, resp_rdata=0; SW 1022 leaves bytes 1022/1023 unchanged on readback with LB.
- Illegal funct3=011 load and SBU-style store (we=1, funct3=100) -> resp_fault=1 one cycle after acceptance; mem_read_en/mem_write_en never asserted.
- Hold resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata stable, req_ready=0 and a pending req_valid ignored; accepted only after the handshake.
- Assert reset during ACCESS of a load -> next cycle IDLE, resp_valid=0, req_ready=1. With LSU_MISALIGN_TRAP_EN: LW 0x11 -> resp_misaligned=1 with no memory enable; without it: normal load result.
